lms_fir_param: RTL and testbench
================================

Name: lms_fir_param

Overview:
- Parametrised successor to the fixed LMS noise-cancelling FIR.
- Takes a reference-noise sample x and a desired/mic sample d per ready_in strobe.
- Computes y = Σ c[k]·x[n−k] over TAPS taps with one time-shared MAC, then error e = d − y, and optionally updates coefficients by sign-exact LMS.
- Adds configurable width/depth/step size, adaptation freeze, saturation, and overrun detection; sits between the ADC sample stream and the anti-noise output path.

Parameters:
- WIDTH, 16, sample width of x_in, d_in, y_out, e_out (signed).
- TAPS, 32, filter length; power of two, 4..64.
- COEF_WIDTH, 18, signed coefficient width; Q1.(COEF_WIDTH−1).
- MU_SHIFT, 12, step size μ = 2^−MU_SHIFT applied to e·x.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, synchronous reset, active-low.
- ready_in, input, 1, one-cycle strobe: new x_in/d_in valid.
- x_in, input, WIDTH, signed reference sample.
- d_in, input, WIDTH, signed desired sample.
- adapt_en_in, input, 1, sampled with ready_in; 1 = update coefficients this sample.
- y_out, output, WIDTH, signed filter output, held between valids.
- e_out, output, WIDTH, signed error, held between valids.
- valid_out, output, 1, one-cycle pulse when y_out/e_out update.
- busy_out, output, 1, high while not IDLE.
- overrun_out, output, 1, sticky; set when ready_in is dropped.

Behaviour:
- Reset (rst_in=0 at posedge): y_out=0, e_out=0, valid_out=0, busy_out=0, overrun_out=0. All coefficients and delay-line entries cleared to 0; state IDLE. Reset mid-operation aborts the computation; no partial coefficient update survives.
- States:
  - IDLE: on ready_in, write x_in at the circular delay-line head (head advances, wraps mod TAPS), latch d_in and adapt_en_in, clear the accumulator, k=0, go to FILTER.
  - FILTER: one MAC per cycle, acc += c[k]·x[n−k], for k=0..TAPS−1 (TAPS cycles), then go to ERROR.
  - ERROR (1 cycle): y = sat_WIDTH(acc >>> (COEF_WIDTH−1)), arithmetic shift, truncate toward −∞; e = sat_WIDTH(d − y). Register y_out/e_out and pulse valid_out on the next cycle. Go to UPDATE if the latched adapt_en=1, else IDLE.
  - UPDATE: one tap per cycle, k=0..TAPS−1: c[k] = sat_COEF(c[k] + ((e·x[n−k]) >>> MU_SHIFT)), using the registered e. Then go to IDLE.
- Latency: ready_in at cycle 0 → valid_out high at cycle TAPS+2. busy_out is high cycles 1..TAPS+1 (no adapt) or 1..2·TAPS+1 (adapt). The caller must space samples by at least 2·TAPS+2 cycles; 66 cycles at defaults, well inside the 128-cycle sample spacing.
- Accumulator width is WIDTH+COEF_WIDTH+log2(TAPS) bits; it never overflows internally. Saturation clamps to [−2^(W−1), 2^(W−1)−1].
- ready_in while busy_out=1: the sample is ignored (delay line, d, and coefficients untouched), overrun_out is set, and it stays set until reset.
- ready_in in the same cycle busy falls is still dropped; acceptance happens only when the state is IDLE at the clock edge.
- adapt_en_in changes mid-operation have no effect on the sample already in progress.

Test Plan:
- Reset/zero: reset, then ready_in with x=1000, d=500, adapt_en=0 → valid_out at cycle TAPS+2, y_out=0, e_out=500, coefficients remain 0.
- Adaptation step, defaults:
  - Sample 1, x=d=8192, adapt_en=1 → y=0, e=8192, c[0] becomes 16384.
  - Sample 2, x=d=8192 → y=(16384·8192)>>>17=1024, e=7168.
- Freeze: repeat the adaptation sequence with adapt_en=0 → y_out=0 and e_out=8192 every sample; busy_out high exactly TAPS+1 cycles.
- Overrun: second ready_in 10 cycles after the first → overrun_out=1 and stays set; exactly one valid_out; output matches the single-sample result.
- Saturation: x=d=32767 held, adapt_en=1 for 200 samples → no coefficient wraps (c[k] ≤ 2^17−1), y_out never wraps sign, e_out within ±32767.
- Reset mid-UPDATE: drive rst_in=0 at cycle TAPS+5 → next sample with x=1000, d=500 gives y_out=0, e_out=500; overrun_out=0.

Source files
------------

// File: rtl/lms_fir_param.sv
// Parametrised LMS noise-cancelling FIR with one time-shared MAC.
// Filters x, forms e = d - y, and optionally adapts coefficients per sample.
module lms_fir_param #(
    parameter int WIDTH      = 16,
    parameter int TAPS       = 32,
    parameter int COEF_WIDTH = 18,
    parameter int MU_SHIFT   = 12
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    ready_in,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] d_in,
    input  logic                    adapt_en_in,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] e_out,
    output logic                    valid_out,
    output logic                    busy_out,
    output logic                    overrun_out
);
    localparam int LG = $clog2(TAPS);
    localparam int PW = WIDTH + COEF_WIDTH;
    localparam int AW = PW + LG;
    localparam int EW = 2 * WIDTH;
    localparam int UW = (EW > COEF_WIDTH ? EW : COEF_WIDTH) + 1;

    localparam logic signed [AW-1:0] WMAX =
        $signed({{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [AW-1:0] WMIN = ~WMAX;
    localparam logic signed [UW-1:0] CMAX =
        $signed({{(UW-COEF_WIDTH+1){1'b0}}, {(COEF_WIDTH-1){1'b1}}});
    localparam logic signed [UW-1:0] CMIN = ~CMAX;

    typedef enum logic [1:0] {IDLE, FILTER, ERROR, UPDATE} state_t;

    state_t state, state_next;

    logic [LG-1:0]                  k;
    logic [LG-1:0]                  head;
    logic                           last;
    logic signed [WIDTH-1:0]        dl [TAPS];
    logic signed [COEF_WIDTH-1:0]   coef [TAPS];
    logic signed [WIDTH-1:0]        d_lat;
    logic                           adapt_lat;
    logic signed [AW-1:0]           acc;

    logic signed [WIDTH-1:0]        xk;
    logic signed [COEF_WIDTH-1:0]   ck;
    logic signed [PW-1:0]           prod;
    logic signed [AW-1:0]           acc_sh;
    logic signed [WIDTH-1:0]        y_sat;
    logic signed [AW-1:0]           diff;
    logic signed [WIDTH-1:0]        e_sat;
    logic signed [EW-1:0]           eprod;
    logic signed [EW-1:0]           esh;
    logic signed [UW-1:0]           csum;
    logic signed [COEF_WIDTH-1:0]   c_new;

    function automatic logic signed [WIDTH-1:0] sat_w(
        input logic signed [AW-1:0] v
    );
        if (v > WMAX)      return WMAX[WIDTH-1:0];
        else if (v < WMIN) return WMIN[WIDTH-1:0];
        else               return v[WIDTH-1:0];
    endfunction

    function automatic logic signed [COEF_WIDTH-1:0] sat_c(
        input logic signed [UW-1:0] v
    );
        if (v > CMAX)      return CMAX[COEF_WIDTH-1:0];
        else if (v < CMIN) return CMIN[COEF_WIDTH-1:0];
        else               return v[COEF_WIDTH-1:0];
    endfunction

    assign last     = (k == LG'(TAPS - 1));
    assign busy_out = (state != IDLE);

    // x[n-k] lives k slots behind the newest sample at head
    assign xk     = dl[head - k];
    assign ck     = coef[k];
    assign prod   = ck * xk;
    assign acc_sh = acc >>> (COEF_WIDTH - 1);
    assign y_sat  = sat_w(acc_sh);
    assign diff   = $signed({{(AW-WIDTH){d_lat[WIDTH-1]}}, d_lat})
                  - $signed({{(AW-WIDTH){y_sat[WIDTH-1]}}, y_sat});
    assign e_sat  = sat_w(diff);
    assign eprod  = e_out * xk;
    assign esh    = eprod >>> MU_SHIFT;
    assign csum   = $signed({{(UW-COEF_WIDTH){ck[COEF_WIDTH-1]}}, ck})
                  + $signed({{(UW-EW){esh[EW-1]}}, esh});
    assign c_new  = sat_c(csum);

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state sequencing: filter pass, error, optional update pass
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (ready_in) state_next = FILTER;
            FILTER:  if (last) state_next = ERROR;
            ERROR:   state_next = adapt_lat ? UPDATE : IDLE;
            UPDATE:  if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: sample capture, MAC, output registers, coefficient update
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < TAPS; i++) begin
                dl[i]   <= '0;
                coef[i] <= '0;
            end
            k           <= '0;
            head        <= '0;
            d_lat       <= '0;
            adapt_lat   <= 1'b0;
            acc         <= '0;
            y_out       <= '0;
            e_out       <= '0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (ready_in && state != IDLE) overrun_out <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (ready_in) begin
                        head                <= head + LG'(1);
                        dl[head + LG'(1)]   <= x_in;
                        d_lat               <= d_in;
                        adapt_lat           <= adapt_en_in;
                        acc                 <= '0;
                        k                   <= '0;
                    end
                end
                FILTER: begin
                    acc <= acc + $signed({{(AW-PW){prod[PW-1]}}, prod});
                    k   <= k + LG'(1);
                end
                ERROR: begin
                    y_out     <= y_sat;
                    e_out     <= e_sat;
                    valid_out <= 1'b1;
                    k         <= '0;
                end
                UPDATE: begin
                    coef[k] <= c_new;
                    k       <= k + LG'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lms_fir_param.sv
// Bench for lms_fir_param: random and directed samples against an
// arithmetic LMS reference, with a queue-based output scoreboard.
module tb_lms_fir_param;
    localparam int W  = 16;
    localparam int T  = 32;
    localparam int CW = 18;
    localparam int MU = 12;

    logic                clk_in = 0;
    logic                rst_in = 0;
    logic                ready_in = 0;
    logic signed [W-1:0] x_in = '0;
    logic signed [W-1:0] d_in = '0;
    logic                adapt_en_in = 0;
    logic signed [W-1:0] y_out;
    logic signed [W-1:0] e_out;
    logic                valid_out;
    logic                busy_out;
    logic                overrun_out;

    lms_fir_param #(.WIDTH(W), .TAPS(T), .COEF_WIDTH(CW), .MU_SHIFT(MU)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .ready_in(ready_in),
        .x_in(x_in), .d_in(d_in), .adapt_en_in(adapt_en_in),
        .y_out(y_out), .e_out(e_out), .valid_out(valid_out),
        .busy_out(busy_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        longint y;
        longint e;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;

    // reference model: mx[0] is newest sample, mc[k] pairs with mx[k]
    longint mx [T];
    longint mc [T];

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic longint sat(input longint v, input int bits);
        longint hi, lo;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -(longint'(1) <<< (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic check(input string name, input longint act,
                         input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // monitor: every valid_out must match the oldest outstanding sample
    always @(negedge clk_in) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_valid: got y=%0d e=%0d, want none",
                         y_out, e_out);
            end else begin
                exp_t ex;
                ex = sb.pop_front();
                vectors++;
                if (longint'(y_out) != ex.y || longint'(e_out) != ex.e ||
                    cyc != ex.cyc) begin
                    miscompares++;
                    $display("FAIL sample: got y=%0d e=%0d cyc=%0d, want y=%0d e=%0d cyc=%0d",
                             y_out, e_out, cyc, ex.y, ex.e, ex.cyc);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < T; i++) begin
            mx[i] = 0;
            mc[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst_in = 0;
        ready_in = 0;
        repeat (3) @(negedge clk_in);
        sb.delete();
        model_reset();
        rst_in = 1;
    endtask

    // drive one accepted sample at a negedge and predict its response
    task automatic issue(input longint x, input longint d, input bit a);
        exp_t   ex;
        longint acc, y, e;
        for (int i = T - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = x;
        acc = 0;
        for (int i = 0; i < T; i++) acc += mc[i] * mx[i];
        y = sat(acc >>> (CW - 1), W);
        e = sat(d - y, W);
        if (a)
            for (int i = 0; i < T; i++)
                mc[i] = sat(mc[i] + ((e * mx[i]) >>> MU), CW);
        ex.y = y;
        ex.e = e;
        ex.cyc = cyc + T + 2;
        sb.push_back(ex);
        x_in = W'(x);
        d_in = W'(d);
        adapt_en_in = a;
        ready_in = 1;
        @(negedge clk_in);
        ready_in = 0;
        adapt_en_in = ~a;
    endtask

    // count busy cycles after an issue; bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy_out && n < 4 * T) begin
            n++;
            @(negedge clk_in);
        end
        if (busy_out) check("busy_timeout", 1, 0);
        repeat (2) @(negedge clk_in);
    endtask

    task automatic sample(input longint x, input longint d, input bit a,
                          input bit chk_busy);
        int n;
        issue(x, d, a);
        wait_idle(n);
        if (chk_busy) check("busy_len", n, a ? 2 * T + 1 : T + 1);
    endtask

    initial begin
        int n;
        model_reset();
        @(negedge clk_in);
        do_reset();
        @(negedge clk_in);
        check("rst_y", y_out, 0);
        check("rst_e", e_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_overrun", overrun_out, 0);

        sample(1000, 500, 0, 1);
        sample(1000, 500, 0, 0);

        do_reset();
        sample(8192, 8192, 1, 1);
        sample(8192, 8192, 1, 1);
        sample(8192, 8192, 1, 0);

        do_reset();
        for (int i = 0; i < 3; i++) sample(8192, 8192, 0, 1);

        // overrun: a second strobe 10 cycles into a computation
        do_reset();
        issue(1000, 500, 0);
        repeat (9) @(negedge clk_in);
        x_in = 12345;
        d_in = -4321;
        adapt_en_in = 1;
        ready_in = 1;
        @(negedge clk_in);
        ready_in = 0;
        wait_idle(n);
        check("overrun_set", overrun_out, 1);
        sample(-700, 300, 0, 1);
        check("overrun_sticky", overrun_out, 1);

        do_reset();
        for (int i = 0; i < 200; i++) sample(32767, 32767, 1, 0);

        // reset during the UPDATE pass must discard the partial update
        do_reset();
        issue(8192, 8192, 1);
        repeat (T + 4) @(negedge clk_in);
        do_reset();
        check("midrst_y", y_out, 0);
        check("midrst_overrun", overrun_out, 0);
        sample(1000, 500, 0, 1);
        check("midrst_overrun2", overrun_out, 0);

        do_reset();
        for (int i = 0; i < 120; i++) begin
            longint x, d;
            bit     a;
            x = longint'($signed(16'($urandom_range(0, 65535))));
            d = longint'($signed(16'($urandom_range(0, 65535))));
            if (i % 3 == 0) begin
                x = x >>> 3;
                d = d >>> 2;
            end
            a = 1'($urandom_range(0, 1));
            sample(x, d, a, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
        end

        repeat (4) @(negedge clk_in);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
